// File: rtl/sr_deframer_pkg.sv
// sr_deframer_pkg: shared state encoding and framing constants for the sync/data/parity deframer.
package sr_deframer_pkg;
    typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
    localparam logic [3:0] SYNC_DEF   = 4'b1011;
    localparam logic [2:0] GUARD_POST = 3'd3;
    localparam logic [2:0] GUARD_RST  = 3'd4;
    localparam int         FRAME_BITS = 8;
endpackage

// File: rtl/sr_deframer_par_chk.sv
// par_chk: parity check over data plus parity bit; ok when the overall parity matches ODD_PAR.
module par_chk #(
    parameter bit ODD_PAR = 1'b0
) (
    input  logic [8:0] i_bits,
    output logic       o_ok
);
    assign o_ok = (^i_bits) == ODD_PAR;
endmodule

// File: rtl/sr_deframer.sv
// sr_deframer: hunts for SYNC in the upstream shift register, captures an 8-bit frame plus parity.
module sr_deframer
    import sr_deframer_pkg::*;
#(
    parameter logic [3:0] SYNC    = SYNC_DEF,
    parameter bit         ODD_PAR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] q,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       par_err,
    output logic       locked,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);
    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_rst_sync;
    logic       w_rst;
    logic [2:0] r_bitcnt;
    logic [2:0] r_guard;
    logic [7:0] r_sh;
    logic [7:0] r_data;
    logic       r_dv;
    logic       r_pe;
    logic [7:0] r_fcnt;
    logic [7:0] r_ecnt;
    logic       w_match;
    logic       w_last;
    logic       w_ok;
    logic       w_shift;
    logic       w_good;
    logic       w_bad;

    // async assert, release two edges after rst falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_sync <= 2'b11;
        else     r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
    assign w_rst = r_rst_sync[1];

    par_chk #(.ODD_PAR(ODD_PAR)) u_par_chk (
        .i_bits ({r_sh, q[0]}),
        .o_ok   (w_ok)
    );

    assign w_match = (r_guard == 3'd0) && ({q[3], q[2], q[1], q[0]} == SYNC);
    assign w_last  = r_bitcnt == 3'(FRAME_BITS - 1);

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_state <= HUNT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == HUNT) ? (w_match ? DATA : HUNT) :
                 (r_state == DATA) ? (w_last ? PAR : DATA) : HUNT;
    end

    always_comb begin
        w_shift = r_state == DATA;
        w_good  = (r_state == PAR) && w_ok;
        w_bad   = (r_state == PAR) && !w_ok;
        locked  = r_state != HUNT;
    end

    // guard reloads after every frame so the next window holds only fresh bits
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_bitcnt <= 3'd0;
            r_guard  <= GUARD_RST;
            r_sh     <= 8'h00;
            r_data   <= 8'h00;
            r_dv     <= 1'b0;
            r_pe     <= 1'b0;
            r_fcnt   <= 8'h00;
            r_ecnt   <= 8'h00;
        end else begin
            r_bitcnt <= w_shift ? r_bitcnt + 3'd1 : 3'd0;
            r_guard  <= (r_state == PAR) ? GUARD_POST :
                        (r_state == HUNT && r_guard != 3'd0) ? r_guard - 3'd1 : r_guard;
            if (w_shift) r_sh <= {r_sh[6:0], q[0]};
            if (w_good) r_data <= r_sh;
            r_dv <= w_good;
            r_pe <= w_bad;
            if (w_good) r_fcnt <= r_fcnt + 8'd1;
            if (w_bad && r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
        end
    end

    assign data       = r_data;
    assign data_valid = r_dv;
    assign par_err    = r_pe;
    assign frame_cnt  = r_fcnt;
    assign err_cnt    = r_ecnt;
endmodule

// File: tb/tb_sr_deframer.sv
// tb_sr_deframer: serial stream through a 4-bit shift register into sr_deframer, scoreboarded frame results.
module tb_sr_deframer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_bit = 1'b0;
    logic [0:3] sr;
    logic [7:0] data;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
    logic       data_valid;
    logic       par_err;
    logic       locked;

    typedef struct {
        logic       good;
        logic [7:0] d;
        logic [7:0] fc;
        logic [7:0] ec;
        int         cyc;
    } ev_t;

    ev_t        obs[$];
    ev_t        exp_q[$];
    int         runs[$];
    int         run = 0;
    int         cyc = 0;
    bit         both_seen = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_fc = 8'h00;
    logic [7:0] m_ec = 8'h00;
    logic [7:0] m_last = 8'h00;

    always #5 clk = ~clk;

    // upstream shift register: q[0] newest, no reset
    always @(posedge clk) sr <= {s_bit, sr[0:2]};
    always @(posedge clk) cyc <= cyc + 1;

    sr_deframer dut (
        .clk        (clk),
        .rst        (rst),
        .q          (sr),
        .data       (data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always @(negedge clk) begin
        ev_t e;
        if (data_valid === 1'b1 && par_err === 1'b1) both_seen = 1'b1;
        if (data_valid === 1'b1 || par_err === 1'b1) begin
            e.good = data_valid;
            e.d    = data;
            e.fc   = frame_cnt;
            e.ec   = err_cnt;
            e.cyc  = cyc;
            obs.push_back(e);
        end
        if (locked === 1'b1) run++;
        else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic send(input logic b);
        s_bit = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0);
    endtask

    task automatic send_sync;
        logic [3:0] s;
        s = 4'b1011;
        for (int i = 3; i >= 0; i--) send(s[i]);
    endtask

    task automatic frame(input logic [7:0] d, input logic p);
        ev_t e;
        e.good = ~^{d, p};
        if (e.good) begin
            m_fc   = m_fc + 8'd1;
            m_last = d;
        end else if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        e.d   = m_last;
        e.fc  = m_fc;
        e.ec  = m_ec;
        e.cyc = 0;
        exp_q.push_back(e);
        send_sync();
        for (int i = 7; i >= 0; i--) send(d[i]);
        send(p);
    endtask

    task automatic wait_obs(input int n, input string tag);
        int k;
        k = 0;
        s_bit = 1'b0;
        while (obs.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " arrival"}, 32'(obs.size() >= n), 32'd1);
    endtask

    task automatic pop_cmp(input string tag);
        ev_t o;
        ev_t e;
        if (obs.size() == 0 || exp_q.size() == 0) return;
        o = obs.pop_front();
        e = exp_q.pop_front();
        chk({tag, " kind"}, 32'(o.good), 32'(e.good));
        chk({tag, " data"}, 32'(o.d), 32'(e.d));
        chk({tag, " frame_cnt"}, 32'(o.fc), 32'(e.fc));
        chk({tag, " err_cnt"}, 32'(o.ec), 32'(e.ec));
    endtask

    task automatic reset_model;
        m_fc   = 8'h00;
        m_ec   = 8'h00;
        m_last = 8'h00;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        int         sp;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst locked", 32'(locked), 32'd0);
        chk("rst data_valid", 32'(data_valid), 32'd0);
        chk("rst par_err", 32'(par_err), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        idle(4);

        frame(8'hA5, 1'b0);
        wait_obs(1, "good");
        pop_cmp("good");
        chk("good locked cycles", 32'(runs.size() > 0 ? runs[0] : -1), 32'd9);

        frame(8'hA5, 1'b1);
        wait_obs(1, "badpar");
        pop_cmp("badpar");

        frame(8'hB0, 1'b1);
        wait_obs(1, "embedded");
        pop_cmp("embedded");
        idle(20);
        chk("embedded extra frames", 32'(obs.size()), 32'd0);

        frame(8'h5A, 1'b0);
        frame(8'hC3, 1'b0);
        wait_obs(2, "b2b");
        sp = (obs.size() >= 2) ? obs[1].cyc - obs[0].cyc : -1;
        chk("b2b spacing", 32'(sp), 32'd13);
        pop_cmp("b2b first");
        pop_cmp("b2b second");

        idle(4);
        send_sync();
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        send(1'b0);
        chk("mid locked before", 32'(locked), 32'd1);
        rst = 1'b1;
        reset_model();
        #1;
        chk("mid locked", 32'(locked), 32'd0);
        chk("mid data_valid", 32'(data_valid), 32'd0);
        chk("mid par_err", 32'(par_err), 32'd0);
        chk("mid frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(12);
        chk("abort no pulse", 32'(obs.size()), 32'd0);
        frame(8'h3C, 1'b0);
        wait_obs(1, "after reset");
        pop_cmp("after reset");

        rst = 1'b1;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(8);
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            frame(d, ^d);
        end
        wait_obs(exp_q.size(), "wrap");
        while (exp_q.size() > 0 && obs.size() > 0) pop_cmp("wrap");
        chk("frame_cnt wrap", 32'(frame_cnt), 32'd0);

        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            frame(d, ~^d);
        end
        wait_obs(exp_q.size(), "sat");
        while (exp_q.size() > 0 && obs.size() > 0) pop_cmp("sat");
        chk("err_cnt saturate", 32'(err_cnt), 32'hFF);
        chk("frame_cnt after bad", 32'(frame_cnt), 32'd0);
        chk("never both pulses", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
